// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI transmit scheduler.
// Frame width depends on the optional SPI_TX_TAG_EN macro: when defined,
// each frame carries a 3-bit requester index ahead of the 16 data bits.
package spi_sched_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;

`ifdef SPI_TX_TAG_EN
  localparam int FW = TAG_W + DATA_W;
`else
  localparam int FW = DATA_W;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift engine: clock divider, bit counter, shift register and
// spi_clk / spi_mosi generation. Sequencing between phases is decided by the
// scheduler FSM; this block only reports divider ticks and the last fall.
// The shift register back-fills zeros, so MOSI is naturally 0 once every
// frame bit has been sent.
module spi_shift_engine
  import spi_sched_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [FW-1:0] frame_i,
  input  logic          run_i,
  input  logic          shift_en_i,
  output logic          tick_o,
  output logic          last_fall_o,
  output logic          spi_clk_o,
  output logic          spi_mosi_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FW);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [FW-1:0]    sreg_q, sreg_d;
  logic             sclk_q, sclk_d;
  logic             last_bit;

  assign tick_o      = run_i && (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit    = (bit_q == BIT_W'(FW - 1));
  assign last_fall_o = shift_en_i && tick_o && sclk_q && last_bit;
  assign spi_clk_o   = sclk_q;
  assign spi_mosi_o  = sreg_q[FW-1];

  // Divider reloads to zero on every tick so it never wraps mid half-period
  always_comb begin
    div_d = div_q;
    if (!run_i || load_i || tick_o) div_d = '0;
    else                            div_d = div_q + 1'b1;
  end

  // Serial clock toggles on ticks while shifting; data moves on each fall
  always_comb begin
    sclk_d = sclk_q;
    sreg_d = sreg_q;
    bit_d  = bit_q;
    if (load_i) begin
      sreg_d = frame_i;
      bit_d  = '0;
      sclk_d = 1'b0;
    end else if (!shift_en_i) begin
      sclk_d = 1'b0;
    end else if (tick_o) begin
      if (!sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        sclk_d = 1'b0;
        sreg_d = {sreg_q[FW-2:0], 1'b0};
        bit_d  = last_bit ? '0 : bit_q + 1'b1;
      end
    end
  end

  // Engine registers, cleared asynchronously so outputs idle at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bit_q  <= '0;
      sreg_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      sreg_q <= sreg_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler sharing one SPI transmit link among NUM_REQ
// requesters. Optional macro SPI_TX_TAG_EN prefixes each frame with the
// 3-bit requester index.
// Handshake: req[k] is a level; while high, req_data slice k must be stable.
// The word is taken in the IDLE cycle that grants k, and ack[k] pulses for
// exactly one cycle right after; a requester that drops req before its
// grant is simply skipped and never acknowledged.
module spi_tx_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 25,
  parameter int GAP_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      spi_clk,
  output logic                      spi_mosi,
  output logic                      spi_ss,
  output logic                      busy,
  output state_e                    state_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx, cand_idx, gnt_next;
  int                 cand;
  logic [DATA_W-1:0]  gnt_data;
  logic [FW-1:0]      frame;
  logic               load, run, shift_en, tick, last_fall;

  // Round-robin search starting at the pointer (one past the last grant)
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  assign gnt_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Select the granted requester's data slice
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) gnt_data = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef SPI_TX_TAG_EN
  assign frame = {TAG_W'(gnt_idx), gnt_data};
`else
  assign frame = gnt_data;
`endif

  // Frame sequencing: grant, setup, shift, hold, inter-frame gap
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    ack_d   = '0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          load    = 1'b1;
          state_d = ST_SETUP;
          ptr_d   = gnt_next;
          for (int i = 0; i < NUM_REQ; i++) ack_d[i] = (gnt_idx == IDX_W'(i));
        end
      end
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (last_fall) state_d = ST_HOLD;
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler registers; reset discards any in-flight frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
    end
  end

  assign run      = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign shift_en = (state_q == ST_SHIFT);
  assign spi_ss   = ~run;
  assign busy     = (state_q != ST_IDLE);
  assign ack      = ack_q;
  assign state_o  = state_q;

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .frame_i     (frame),
    .run_i       (run),
    .shift_en_i  (shift_en),
    .tick_o      (tick),
    .last_fall_o (last_fall),
    .spi_clk_o   (spi_clk),
    .spi_mosi_o  (spi_mosi)
  );

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Bench for spi_tx_scheduler (CLK_DIV=2, GAP_CYC=4, NUM_REQ=4).
// Frames are captured off the wire by a monitor and compared with words
// predicted by a round-robin model kept in the bench.
module tb_spi_tx_scheduler;
  import spi_sched_pkg::*;

  localparam int N      = 4;
  localparam int CD     = 2;
  localparam int GAP    = 4;
  localparam int FWB    = FW;
  localparam int SS_LOW = CD * (2 * FWB + 2);
  localparam int PERIOD = 1 + SS_LOW + GAP;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*16-1:0] req_data;
  logic [N-1:0]  ack;
  logic          spi_clk, spi_mosi, spi_ss, busy;
  state_e        state;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  int cyc_n = 0;
  logic [31:0] exp_q[$];

  spi_tx_scheduler #(.NUM_REQ(N), .CLK_DIV(CD), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_ss(spi_ss), .busy(busy),
    .state_o(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // monitor: collect each frame seen while spi_ss is low
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [31:0] acc = '0;
  int          nb = 0;
  int          low = 0;
  logic [31:0] frm_bits_q[$];
  int          frm_n_q[$];
  int          frm_low_q[$];

  always @(negedge clk) begin
    if (!spi_ss) begin
      if (prev_ss) begin
        acc = '0;
        nb  = 0;
        low = 0;
      end
      low++;
      if (spi_clk && !prev_sclk) begin
        acc = {acc[30:0], spi_mosi};
        nb++;
      end
    end else if (!prev_ss) begin
      frm_bits_q.push_back(acc);
      frm_n_q.push_back(nb);
      frm_low_q.push_back(low);
    end
    prev_ss   = spi_ss;
    prev_sclk = spi_clk;
  end

  // reference model
  function automatic logic [31:0] exp_frame(int idx, logic [15:0] d);
`ifdef SPI_TX_TAG_EN
    return {13'd0, idx[2:0], d};
`else
    return {16'd0, d};
`endif
  endfunction

  function automatic int rr_pick(logic [3:0] m, int p);
    int c;
    for (int i = 0; i < N; i++) begin
      c = (p + i) % N;
      if (m[c[1:0]]) return c;
    end
    return -1;
  endfunction

  // driver helpers
  task automatic wait_ack(input int budget, output logic [3:0] av, output int cyc);
    av  = '0;
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        av  = ack;
        cyc = cyc_n;
        break;
      end
    end
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (frm_bits_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    total++; if (spi_ss !== 1'b1) begin bad++; $display("FAIL rst_ss: got=%b want=1", spi_ss); end
    total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL rst_sclk: got=%b want=0", spi_clk); end
    total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi: got=%b want=0", spi_mosi); end
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL rst_ack: got=%b want=0000", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b want=0", busy); end
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got=%0d want=%0d", state, ST_IDLE); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || spi_ss !== 1'b1) begin bad++; $display("FAIL idle_after_rst: busy=%b ss=%b want 0/1", busy, spi_ss); end
    ptr_m = 0;
  endtask

  task automatic test_single(input int k, input logic [15:0] d);
    int base, extra, cyc;
    logic [3:0] av;
    logic [31:0] expv;
    bit ok;
    @(posedge clk);
    base = frm_bits_q.size();
    @(negedge clk);
    req_data[k*16 +: 16] = d;
    exp_q.push_back(exp_frame(k, d));
    ptr_m = (rr_pick(4'(1 << k), ptr_m) + 1) % N;
    req[k] = 1'b1;
    wait_ack(PERIOD + 10, av, cyc);
    req[k] = 1'b0;
    total++; if (av !== 4'(1 << k)) begin bad++; $display("FAIL single_ack[%0d]: got=%b want=%b", k, av, 4'(1 << k)); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got=%b want=1", busy); end
    wait_frames(base + 1, 2 * PERIOD, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_frame_timeout: got=%0d frames want=%0d", frm_bits_q.size() - base, 1); end
    extra = 0;
    for (int i = 0; i < GAP + 20; i++) begin
      @(negedge clk);
      if (ack != 4'b0) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL single_extra_ack: got=%0d want=0", extra); end
    expv = exp_q.pop_front();
    if (ok) begin
      total++; if (frm_bits_q[base] !== expv) begin bad++; $display("FAIL single_bits: got=%h want=%h", frm_bits_q[base], expv); end
      total++; if (frm_n_q[base] != FWB) begin bad++; $display("FAIL single_rises: got=%0d want=%0d", frm_n_q[base], FWB); end
      total++; if (frm_low_q[base] != SS_LOW) begin bad++; $display("FAIL single_ss_low: got=%0d want=%0d", frm_low_q[base], SS_LOW); end
    end
  endtask

  task automatic test_random();
    logic [3:0] mask, pend, av;
    logic [15:0] d[4];
    int order[$];
    int base, p, g, cyc;
    logic [31:0] expv;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      @(posedge clk);
      base = frm_bits_q.size();
      @(negedge clk);
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        d[k] = 16'($urandom);
        req_data[k*16 +: 16] = d[k];
      end
      pend = mask;
      p = ptr_m;
      order.delete();
      while (pend != 4'b0) begin
        g = rr_pick(pend, p);
        order.push_back(g);
        exp_q.push_back(exp_frame(g, d[g]));
        pend[g[1:0]] = 1'b0;
        p = (g + 1) % N;
      end
      ptr_m = p;
      req = mask;
      for (int i = 0; i < order.size(); i++) begin
        wait_ack(PERIOD + 10, av, cyc);
        total++; if (av !== 4'(1 << order[i])) begin bad++; $display("FAIL rand_ack it%0d #%0d: got=%b want=%b", it, i, av, 4'(1 << order[i])); end
        if (av == 4'b0) req = '0;
        else req = req & ~av;
      end
      req = '0;
      wait_frames(base + order.size(), PERIOD * (order.size() + 1), ok);
      total++; if (!ok) begin bad++; $display("FAIL rand_frame_timeout it%0d: got=%0d want=%0d", it, frm_bits_q.size() - base, order.size()); end
      for (int i = 0; i < order.size(); i++) begin
        expv = exp_q.pop_front();
        if (ok) begin
          total++; if (frm_bits_q[base + i] !== expv) begin bad++; $display("FAIL rand_bits it%0d #%0d: got=%h want=%h", it, i, frm_bits_q[base + i], expv); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d[4];
    int got[$];
    int cycs[$];
    int base, p, g, cyc;
    logic [3:0] av;
    logic [31:0] expv;
    bit ok;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    @(posedge clk);
    base = frm_bits_q.size();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      d[k] = 16'($urandom);
      req_data[k*16 +: 16] = d[k];
    end
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(PERIOD + 10, av, cyc);
      got.push_back((av == 4'b0) ? -1 : $clog2(av));
      cycs.push_back(cyc);
      if (i == 4 || av == 4'b0) req = '0;
      if (av == 4'b0) break;
    end
    req = '0;
    p = ptr_m;
    for (int i = 0; i < 5; i++) begin
      g = rr_pick(4'b1111, p);
      p = (g + 1) % N;
      exp_q.push_back(exp_frame(g, d[g]));
      total++;
      if (i >= got.size() || got[i] != g) begin
        bad++; $display("FAIL b2b_order #%0d: got=%0d want=%0d", i, (i < got.size()) ? got[i] : -1, g);
      end
      if (i > 0 && i < cycs.size()) begin
        total++; if (cycs[i] - cycs[i-1] != PERIOD) begin bad++; $display("FAIL b2b_spacing #%0d: got=%0d want=%0d", i, cycs[i] - cycs[i-1], PERIOD); end
      end
    end
    ptr_m = p;
    wait_frames(base + 5, PERIOD * 6, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_frame_timeout: got=%0d want=5", frm_bits_q.size() - base); end
    for (int i = 0; i < 5; i++) begin
      expv = exp_q.pop_front();
      if (ok) begin
        total++; if (frm_bits_q[base + i] !== expv) begin bad++; $display("FAIL b2b_bits #%0d: got=%h want=%h", i, frm_bits_q[base + i], expv); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    logic [3:0] av;
    logic [31:0] expv;
    logic pv;
    int rises, base, cyc;
    bit ok;
    d = 16'($urandom);
    @(negedge clk);
    req_data[2*16 +: 16] = d;
    req[2] = 1'b1;
    wait_ack(PERIOD + 10, av, cyc);
    total++; if (av !== 4'b0100) begin bad++; $display("FAIL mid_first_ack: got=%b want=0100", av); end
    rises = 0;
    pv = spi_clk;
    for (int i = 0; i < PERIOD && rises < 7; i++) begin
      @(negedge clk);
      if (spi_clk && !pv) rises++;
      pv = spi_clk;
    end
    total++; if (rises != 7) begin bad++; $display("FAIL mid_rise_timeout: got=%0d want=7", rises); end
    rst_n = 1'b0;
    #1;
    total++; if (spi_ss !== 1'b1) begin bad++; $display("FAIL mid_rst_ss: got=%b want=1", spi_ss); end
    total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL mid_rst_sclk: got=%b want=0", spi_clk); end
    total++; if (spi_mosi !== 1'b0 || busy !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL mid_rst_outs: got mosi=%b busy=%b ack=%b want 0/0/0000", spi_mosi, busy, ack); end
    repeat (3) @(negedge clk);
    @(posedge clk);
    base = frm_bits_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 3;
    exp_q.push_back(exp_frame(2, d));
    wait_ack(PERIOD + 10, av, cyc);
    req[2] = 1'b0;
    total++; if (av !== 4'b0100) begin bad++; $display("FAIL mid_fresh_ack: got=%b want=0100", av); end
    wait_frames(base + 1, 2 * PERIOD, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_frame_timeout: got=%0d want=1", frm_bits_q.size() - base); end
    expv = exp_q.pop_front();
    if (ok) begin
      total++; if (frm_bits_q[base] !== expv || frm_n_q[base] != FWB) begin
        bad++; $display("FAIL mid_fresh_frame: got=%h/%0d bits want=%h/%0d", frm_bits_q[base], frm_n_q[base], expv, FWB);
      end
    end
  endtask

  task automatic test_pulse();
    logic [15:0] d;
    logic [3:0] av;
    logic [31:0] expv;
    int base, cyc, acks, seen;
    bit ok;
    d = 16'($urandom);
    @(posedge clk);
    base = frm_bits_q.size();
    @(negedge clk);
    req_data[0 +: 16] = d;
    req_data[3*16 +: 16] = 16'($urandom);
    req[0] = 1'b1;
    exp_q.push_back(exp_frame(0, d));
    wait_ack(PERIOD + 10, av, cyc);
    req[0] = 1'b0;
    ptr_m = 1;
    total++; if (av !== 4'b0001) begin bad++; $display("FAIL pulse_first_ack: got=%b want=0001", av); end
    seen = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (spi_clk) begin
        seen = 1;
        break;
      end
    end
    total++; if (seen == 0) begin bad++; $display("FAIL pulse_shift_timeout: got=%0d want=1", seen); end
    req[3] = 1'b1;
    @(negedge clk);
    req[3] = 1'b0;
    acks = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (ack != 4'b0) acks++;
    end
    @(posedge clk);
    total++; if (acks != 0) begin bad++; $display("FAIL pulse_stray_ack: got=%0d want=0", acks); end
    total++; if (frm_bits_q.size() != base + 1) begin bad++; $display("FAIL pulse_frame_count: got=%0d want=1", frm_bits_q.size() - base); end
    ok = (frm_bits_q.size() > base);
    expv = exp_q.pop_front();
    if (ok) begin
      total++; if (frm_bits_q[base] !== expv) begin bad++; $display("FAIL pulse_bits: got=%h want=%h", frm_bits_q[base], expv); end
    end
  endtask

  initial begin
    test_reset();
    test_single(1, 16'hA5C3);
    test_single(2, 16'h0001);
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_scheduler.md
SPI_TX_SCHEDULER -- requirements
Module: spi_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing the SPI link (2..8).
REQ-002 SHALL have parameter CLK_DIV, default 25, meaning clk cycles per SCLK half-period (>=1); 250 MHz / 50 = 5 MHz.
REQ-003 SHALL have parameter GAP_CYC, default 4, meaning idle clk cycles with spi_ss high between frames (>=1).
REQ-004 SHALL have port clk, input, 1, system clock, 250 MHz.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port req, input, NUM_REQ, per-requester level request; holding high means a word is pending.
REQ-007 SHALL have port req_data, input, NUM_REQ*16, per-requester word; slice k is [16k+15:16k]; stable while req[k] is high.
REQ-008 SHALL have port ack, output, NUM_REQ, one-cycle pulse at which the word of requester k is latched.
REQ-009 SHALL have ports spi_clk, spi_mosi and spi_ss: outputs, 1 bit each; serial clock (idle low), data, and active-low select.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-012 In IDLE with any req bit high, SHALL grant round-robin, starting from the index after the last granted requester (index 0 after reset).
REQ-013 On the grant cycle, SHALL pulse ack[k] for exactly 1 cycle, latch the requester's slice (plus tag, see REQ-023), and enter SETUP.
REQ-014 A req bit that drops before its grant cycle SHALL receive no ack; at most one ack bit SHALL be high per cycle.
REQ-015 SETUP: spi_ss low and spi_mosi = frame MSB from the first SETUP cycle, held CLK_DIV cycles, then enter SHIFT.
REQ-016 SHIFT, mode 0: spi_clk rises after each CLK_DIV cycles and falls after CLK_DIV more.
REQ-017 SHIFT: spi_mosi SHALL update to the next bit, MSB first, on each spi_clk fall; a frame is FW rising edges.
REQ-018 After the FW-th falling edge, SHALL enter HOLD: spi_mosi=0 and spi_ss low for CLK_DIV cycles.
REQ-019 After HOLD, SHALL set spi_ss high and stay in GAP for GAP_CYC cycles, then return to IDLE; requests arriving during a frame wait.
REQ-020 A frame SHALL span 1 grant cycle + CLK_DIV*(2*FW+2) + GAP_CYC cycles from ack to the next possible ack.
REQ-021 Internal counters SHALL saturate or reload without wrap-around glitches on spi_clk.

Reset
REQ-022 On rst_n low, at any time including mid-frame, SHALL immediately force: state IDLE, spi_ss=1, spi_clk=0, spi_mosi=0, ack=0, busy=0, round-robin pointer to index 0; the in-flight frame is discarded with no ack re-issue.

Configuration
REQ-023 With SPI_TX_TAG_EN defined, FW=19: 3-bit requester index MSB-first, then 16 data bits MSB-first. Without it, FW=16: data bits only. Timing rules are otherwise identical.

Structure
REQ-024 Package spi_sched_pkg SHALL hold the state enum, the data width constant 16, the tag width constant 3, and the FW derivation.
REQ-025 Sub-module spi_shift_engine SHALL hold the divider, bit counter, shift register and spi_clk/spi_mosi generation; the scheduler FSM and arbiter remain in the top level.

Verification
REQ-026 Config: CLK_DIV=2, tag off, req[1]=1, data 0xA5C3. Required: single ack[1] pulse; 16 spi_clk rises; MOSI sampled on rises = 1010_0101_1100_0011; spi_ss low 68 cycles.
REQ-027 req=4'b1111 held continuously. Required: ack order 0,1,2,3,0; ack pulses spaced exactly per REQ-020.
REQ-028 SPI_TX_TAG_EN defined, req[2] with data 0x0001. Required: 19 bits = 010 + 0x0001, last bit 1.
REQ-029 rst_n asserted at the 7th spi_clk rise. Required: spi_ss=1 and spi_clk=0 the same instant; after release, with req still high, a fresh full frame is sent.
REQ-030 req[3] pulsed 1 cycle during SHIFT and low by IDLE. Required: no ack[3]; no frame follows.
